systolic_mac_pe: RTL and testbench
==================================

# systolic_mac_pe

Parametrised output-stationary processing element for the systolic GEMM array. It forwards operands east (A) and south (B) with a one-cycle register stage and valid tags. When both operands are valid it multiply-accumulates into a local accumulator, which supports signed or unsigned mode and optional saturation. A separate double-buffered drain register lets a finished tile's result shift out down the column while the next tile accumulates.

## Interface
- DW, 8: operand width (A and B).
- AW, 32: accumulator and result width; AW >= 2*DW.
- SIGNED, 1: 1 = two's-complement operands and accumulator; 0 = unsigned.
- SAT, 1: 1 = saturate accumulator on overflow; 0 = wrap modulo 2^AW.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- a_in  in  DW  west operand.
- a_vin  in  1  a_in valid.
- b_in  in  DW  north operand.
- b_vin  in  1  b_in valid.
- acc_clr  in  1  start new tile; qualifies the current cycle.
- a_out  out  DW  registered a_in, to east neighbour.
- a_vout  out  1  registered a_vin.
- b_out  out  DW  registered b_in, to south neighbour.
- b_vout  out  1  registered b_vin.
- acc  out  AW  current accumulator value.
- ovf  out  1  sticky overflow flag for the current tile.
- err  out  1  sticky operand-skew error.
- drain_load  in  1  copy acc into drain register.
- drain_shift  in  1  shift column drain chain.
- drain_in  in  AW  drain value from north PE.
- drain_out  out  AW  drain register contents, to south PE.

## Operation
- fire = a_vin & b_vin. prod = a_in*b_in, 2*DW bits; signed when SIGNED=1, sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to AW.
- Pass-through: a_out, b_out, a_vout and b_vout load every cycle, unconditionally.
- Accumulator update, per cycle:
  - acc_clr & fire: acc <= prod; ovf <= 0.
  - acc_clr & !fire: acc <= 0; ovf <= 0.
  - !acc_clr & fire: acc <= acc + prod, computed at AW+1 bits.
  - otherwise: acc holds.
- Overflow:
  - Signed: both operands have the same sign and the sum sign differs.
  - Unsigned: carry out of bit AW-1.
  - On overflow, ovf <= 1, sticky until acc_clr or reset.
  - SAT=1: acc clamps to 2^(AW-1)-1 / -2^(AW-1) (signed) or 2^AW-1 (unsigned).
  - SAT=0: acc takes the wrapped sum.
- err: set to 1 when a_vin ^ b_vin. Sticky until reset only; acc_clr does not clear it. No MAC occurs in that cycle.
- Drain register:
  - drain_load: drain_out <= acc, using the pre-edge value, i.e. excluding any MAC firing the same cycle.
  - drain_shift without drain_load: drain_out <= drain_in.
  - Both asserted: load wins.
  - Neither asserted: drain_out holds.
- Drain operation is independent of MAC; accumulation continues during shifting.

## Timing
- Reset values: a_out=0, b_out=0, a_vout=0, b_vout=0, acc=0, ovf=0, err=0, drain_out=0.
- Pass-through latency: 1 cycle.
- Accumulate: acc reflects a fire one cycle later. Back-to-back fires every cycle are supported at full throughput.
- Tile end: assert drain_load in the cycle after the last fire, which may coincide with the next tile's acc_clr. drain_out is valid on the following cycle.
- Column drain: for an N-deep column, drain_shift is held N cycles after drain_load. The bottom PE's drain_out presents rows bottom-first, one per cycle.
- Reset asserted mid-tile: all state clears asynchronously. Partial sums are discarded and drain contents are lost.
- acc_clr and saturation in the same cycle: clear semantics apply, and ovf=0 after the edge.

## Test plan
- Reset, then a single fire with SIGNED=1, a=3, b=-4, acc_clr=1: next cycle acc=-12 (0xFFFFFFF4), a_out=3, b_out=0xFC, vouts=1.
- Four fires a=b=1..4 with acc_clr on the first only: acc=30 one cycle after the fourth; then drain_load gives drain_out=30 while a new acc_clr/fire with a=b=2 gives acc=4.
- SIGNED=1, SAT=1, AW=16: repeated 127*127 fires: acc clamps at 32767 with ovf=1; acc_clr clears ovf to 0. With SAT=0 the same stimulus wraps and ovf=1.
- SIGNED=0: a=b=255 gives acc=65025. a_vin=1, b_vin=0 gives err=1, acc unchanged, a_vout=1, b_vout=0.
- Simultaneous drain_load and drain_shift with acc=7, drain_in=9: drain_out=7. Next cycle, shift only: drain_out=9.
- Assert rst_n low mid-accumulation at a non-edge time: all outputs are 0 immediately, and the first post-reset fire without acc_clr accumulates from 0.

Source files
------------

// File: rtl/systolic_mac_pe.sv
// Output-stationary systolic GEMM processing element: forwards A east and B south,
// multiply-accumulates with optional signed/saturating arithmetic, and double-buffers results into a drain chain.
module systolic_mac_pe #(
  parameter int DW     = 8,
  parameter int AW     = 32,
  parameter bit SIGNED = 1'b1,
  parameter bit SAT    = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] a_in,
  input  logic          a_vin,
  input  logic [DW-1:0] b_in,
  input  logic          b_vin,
  input  logic          acc_clr,
  output logic [DW-1:0] a_out,
  output logic          a_vout,
  output logic [DW-1:0] b_out,
  output logic          b_vout,
  output logic [AW-1:0] acc,
  output logic          ovf,
  output logic          err,
  input  logic          drain_load,
  input  logic          drain_shift,
  input  logic [AW-1:0] drain_in,
  output logic [AW-1:0] drain_out
);

  localparam logic [AW-1:0] MAX_S = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] MIN_S = {1'b1, {(AW-1){1'b0}}};
  localparam logic [AW-1:0] MAX_U = {AW{1'b1}};

  logic                   fire;
  logic signed [2*DW-1:0] prod_s;
  logic        [2*DW-1:0] prod_u;
  logic        [AW-1:0]   prod_ext;
  logic        [AW:0]     sum;
  logic                   mac_ovf;
  logic        [AW-1:0]   sat_val;
  logic        [AW-1:0]   mac_val;

  assign fire   = a_vin & b_vin;
  assign prod_s = $signed(a_in) * $signed(b_in);
  assign prod_u = a_in * b_in;

  // NOTE: combinational logic uses blocking '=' with every output given a default first, so no latch can be inferred.
  always_comb begin
    prod_ext = '0;
    mac_ovf  = 1'b0;
    sat_val  = MAX_U;
    if (SIGNED) prod_ext = AW'(prod_s);
    else        prod_ext = AW'(prod_u);
    sum = {1'b0, acc} + {1'b0, prod_ext};
    if (SIGNED) begin
      // Signed overflow: addends agree in sign but the result does not.
      mac_ovf = (acc[AW-1] == prod_ext[AW-1]) && (sum[AW-1] != acc[AW-1]);
      sat_val = acc[AW-1] ? MIN_S : MAX_S;
    end else begin
      mac_ovf = sum[AW];
      sat_val = MAX_U;
    end
    mac_val = (SAT && mac_ovf) ? sat_val : sum[AW-1:0];
  end

  // NOTE: sequential state uses non-blocking '<=' and clears asynchronously on rst_n low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out     <= '0;
      b_out     <= '0;
      a_vout    <= 1'b0;
      b_vout    <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      drain_out <= '0;
    end else begin
      a_out  <= a_in;
      b_out  <= b_in;
      a_vout <= a_vin;
      b_vout <= b_vin;

      if (acc_clr) begin
        acc <= fire ? prod_ext : '0;
        ovf <= 1'b0;
      end else if (fire) begin
        acc <= mac_val;
        if (mac_ovf) ovf <= 1'b1;
      end

      if (a_vin ^ b_vin) err <= 1'b1;

      // Load samples the pre-edge accumulator, so a same-cycle fire lands in the next tile.
      if (drain_load)       drain_out <= acc;
      else if (drain_shift) drain_out <= drain_in;
    end
  end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Directed table-driven bench for systolic_mac_pe across signed/unsigned and saturating/wrapping builds.
module tb_systolic_mac_pe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  a_in, b_in;
  logic        a_vin, b_vin, acc_clr, drain_load, drain_shift;
  logic [31:0] drain_in;

  // Default build: DW=8, AW=32, signed, saturating.
  logic [7:0]  a_out, b_out;
  logic        a_vout, b_vout, ovf, err;
  logic [31:0] acc, drain_out;

  // AW=16 signed saturating / wrapping, and AW=32 unsigned.
  logic [7:0]  s_aout, s_bout, w_aout, w_bout, u_aout, u_bout;
  logic        s_avout, s_bvout, s_ovf, s_err, w_avout, w_bvout, w_ovf, w_err;
  logic        u_avout, u_bvout, u_ovf, u_err;
  logic [15:0] s_acc, s_drain, w_acc, w_drain;
  logic [31:0] u_acc, u_drain;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  systolic_mac_pe dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .a_vin(a_vin), .b_in(b_in), .b_vin(b_vin),
    .acc_clr(acc_clr), .a_out(a_out), .a_vout(a_vout), .b_out(b_out), .b_vout(b_vout),
    .acc(acc), .ovf(ovf), .err(err), .drain_load(drain_load), .drain_shift(drain_shift),
    .drain_in(drain_in), .drain_out(drain_out));

  systolic_mac_pe #(.DW(8), .AW(16), .SIGNED(1'b1), .SAT(1'b1)) dut_s16 (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .a_vin(a_vin), .b_in(b_in), .b_vin(b_vin),
    .acc_clr(acc_clr), .a_out(s_aout), .a_vout(s_avout), .b_out(s_bout), .b_vout(s_bvout),
    .acc(s_acc), .ovf(s_ovf), .err(s_err), .drain_load(drain_load), .drain_shift(drain_shift),
    .drain_in(drain_in[15:0]), .drain_out(s_drain));

  systolic_mac_pe #(.DW(8), .AW(16), .SIGNED(1'b1), .SAT(1'b0)) dut_w16 (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .a_vin(a_vin), .b_in(b_in), .b_vin(b_vin),
    .acc_clr(acc_clr), .a_out(w_aout), .a_vout(w_avout), .b_out(w_bout), .b_vout(w_bvout),
    .acc(w_acc), .ovf(w_ovf), .err(w_err), .drain_load(drain_load), .drain_shift(drain_shift),
    .drain_in(drain_in[15:0]), .drain_out(w_drain));

  systolic_mac_pe #(.DW(8), .AW(32), .SIGNED(1'b0), .SAT(1'b1)) dut_u (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .a_vin(a_vin), .b_in(b_in), .b_vin(b_vin),
    .acc_clr(acc_clr), .a_out(u_aout), .a_vout(u_avout), .b_out(u_bout), .b_vout(u_bvout),
    .acc(u_acc), .ovf(u_ovf), .err(u_err), .drain_load(drain_load), .drain_shift(drain_shift),
    .drain_in(drain_in), .drain_out(u_drain));

  typedef struct {
    logic [7:0]  a;
    logic        av;
    logic [7:0]  b;
    logic        bv;
    logic        clr, dl, ds;
    logic [31:0] din;
    logic [31:0] e_acc;
    logic        e_ovf, e_err;
    logic [31:0] e_drain;
    logic [7:0]  e_aout, e_bout;
    logic        e_avout, e_bvout;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic [7:0] a, logic av, logic [7:0] b, logic bv,
                              logic clr, logic dl, logic ds, logic [31:0] din,
                              logic [31:0] e_acc, logic e_ovf, logic e_err, logic [31:0] e_drain,
                              logic [7:0] e_aout, logic [7:0] e_bout, logic e_avout, logic e_bvout);
    vec_t v;
    v.a = a; v.av = av; v.b = b; v.bv = bv; v.clr = clr; v.dl = dl; v.ds = ds; v.din = din;
    v.e_acc = e_acc; v.e_ovf = e_ovf; v.e_err = e_err; v.e_drain = e_drain;
    v.e_aout = e_aout; v.e_bout = e_bout; v.e_avout = e_avout; v.e_bvout = e_bvout;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic av, input logic [7:0] b, input logic bv,
                       input logic clr, input logic dl, input logic ds, input logic [31:0] din);
    a_in = a; a_vin = av; b_in = b; b_vin = bv;
    acc_clr = clr; drain_load = dl; drain_shift = ds; drain_in = din;
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    tbl[0]  = mk(8'h03, 1, 8'hFC, 1, 1, 0, 0, 32'h0,  32'hFFFF_FFF4, 0, 0, 32'h0,  8'h03, 8'hFC, 1, 1);
    tbl[1]  = mk(8'h01, 1, 8'h01, 1, 1, 0, 0, 32'h0,  32'd1,         0, 0, 32'h0,  8'h01, 8'h01, 1, 1);
    tbl[2]  = mk(8'h02, 1, 8'h02, 1, 0, 0, 0, 32'h0,  32'd5,         0, 0, 32'h0,  8'h02, 8'h02, 1, 1);
    tbl[3]  = mk(8'h03, 1, 8'h03, 1, 0, 0, 0, 32'h0,  32'd14,        0, 0, 32'h0,  8'h03, 8'h03, 1, 1);
    tbl[4]  = mk(8'h04, 1, 8'h04, 1, 0, 0, 0, 32'h0,  32'd30,        0, 0, 32'h0,  8'h04, 8'h04, 1, 1);
    tbl[5]  = mk(8'h02, 1, 8'h02, 1, 1, 1, 0, 32'h0,  32'd4,         0, 0, 32'd30, 8'h02, 8'h02, 1, 1);
    tbl[6]  = mk(8'h00, 0, 8'h00, 0, 0, 0, 1, 32'h55, 32'd4,         0, 0, 32'h55, 8'h00, 8'h00, 0, 0);
    tbl[7]  = mk(8'hFF, 1, 8'hFF, 1, 0, 0, 0, 32'h0,  32'd5,         0, 0, 32'h55, 8'hFF, 8'hFF, 1, 1);
    tbl[8]  = mk(8'h80, 1, 8'h7F, 1, 1, 0, 0, 32'h0,  32'hFFFF_C080, 0, 0, 32'h55, 8'h80, 8'h7F, 1, 1);
    tbl[9]  = mk(8'h05, 1, 8'h06, 0, 0, 0, 0, 32'h0,  32'hFFFF_C080, 0, 1, 32'h55, 8'h05, 8'h06, 1, 0);
    tbl[10] = mk(8'h00, 0, 8'h00, 0, 1, 0, 0, 32'h0,  32'd0,         0, 1, 32'h55, 8'h00, 8'h00, 0, 0);
    tbl[11] = mk(8'h07, 1, 8'h01, 1, 1, 0, 0, 32'h0,  32'd7,         0, 1, 32'h55, 8'h07, 8'h01, 1, 1);
    tbl[12] = mk(8'h00, 0, 8'h00, 0, 0, 1, 1, 32'd9,  32'd7,         0, 1, 32'd7,  8'h00, 8'h00, 0, 0);
    tbl[13] = mk(8'h00, 0, 8'h00, 0, 0, 0, 1, 32'd9,  32'd7,         0, 1, 32'd9,  8'h00, 8'h00, 0, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc", acc, 0);
    check("rst_ovf", ovf, 0);
    check("rst_err", err, 0);
    check("rst_drain", drain_out, 0);
    check("rst_vouts", {a_vout, b_vout}, 0);
    check("rst_aout", a_out, 0);
    check("rst_bout", b_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].a, tbl[i].av, tbl[i].b, tbl[i].bv, tbl[i].clr, tbl[i].dl, tbl[i].ds, tbl[i].din);
      step();
      check($sformatf("v%0d_acc", i), acc, tbl[i].e_acc);
      check($sformatf("v%0d_ovf", i), ovf, tbl[i].e_ovf);
      check($sformatf("v%0d_err", i), err, tbl[i].e_err);
      check($sformatf("v%0d_drain", i), drain_out, tbl[i].e_drain);
      check($sformatf("v%0d_aout", i), a_out, tbl[i].e_aout);
      check($sformatf("v%0d_bout", i), b_out, tbl[i].e_bout);
      check($sformatf("v%0d_vouts", i), {a_vout, b_vout}, {tbl[i].e_avout, tbl[i].e_bvout});
    end

    // Asynchronous reset in the middle of a tile.
    drive(8'h02, 1, 8'h03, 1, 1, 0, 0, 32'h0);
    step();
    check("mid_acc6", acc, 6);
    drive(8'h01, 1, 8'h01, 1, 0, 0, 0, 32'h0);
    step();
    check("mid_acc7", acc, 7);
    drive(8'h04, 1, 8'h05, 1, 0, 0, 0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_acc", acc, 0);
    check("async_err", err, 0);
    check("async_drain", drain_out, 0);
    check("async_pass", {a_out, b_out, a_vout, b_vout}, 0);
    check("async_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_acc", acc, 20);

    // Saturation vs wrap at AW=16: 127*127 = 16129 per fire.
    drive(8'd127, 1, 8'd127, 1, 1, 0, 0, 32'h0);
    step();
    check("sat_first", s_acc, 16129);
    check("wrap_first", w_acc, 16129);
    begin
      logic [15:0] exp_s[3];
      logic [15:0] exp_w[3];
      logic        exp_o[3];
      exp_s[0] = 16'd32258; exp_s[1] = 16'h7FFF; exp_s[2] = 16'h7FFF;
      exp_w[0] = 16'd32258; exp_w[1] = 16'hBD03; exp_w[2] = 16'hFC04;
      exp_o[0] = 1'b0;      exp_o[1] = 1'b1;     exp_o[2] = 1'b1;
      drive(8'd127, 1, 8'd127, 1, 0, 0, 0, 32'h0);
      for (int k = 0; k < 3; k++) begin
        step();
        check($sformatf("sat_acc%0d", k), s_acc, exp_s[k]);
        check($sformatf("sat_ovf%0d", k), s_ovf, exp_o[k]);
        check($sformatf("wrap_acc%0d", k), w_acc, exp_w[k]);
        check($sformatf("wrap_ovf%0d", k), w_ovf, exp_o[k]);
      end
    end
    drive(8'd127, 1, 8'd127, 1, 1, 0, 0, 32'h0);
    step();
    check("sat_clr_acc", s_acc, 16129);
    check("sat_clr_ovf", s_ovf, 0);
    check("wrap_clr_ovf", w_ovf, 0);

    // Unsigned build, then operand skew.
    drive(8'hFF, 1, 8'hFF, 1, 1, 0, 0, 32'h0);
    step();
    check("uns_acc", u_acc, 65025);
    check("uns_err0", u_err, 0);
    check("sgn_m1sq", acc, 1);
    drive(8'h09, 1, 8'h03, 0, 0, 0, 0, 32'h0);
    step();
    check("uns_skew_err", u_err, 1);
    check("uns_skew_acc", u_acc, 65025);
    check("uns_skew_vouts", {u_avout, u_bvout}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
